btn_pulse_conditioner: RTL and testbench

//   Upstream stage for the 4-bit user counter. Turns a raw, bouncing, asynchronous

---
 rtl/btn_cond_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/btn_pulse_conditioner.sv | 121 ++++++++++++
 tb/tb_btn_pulse_conditioner.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_cond_pkg.sv
// Shared definitions for the button conditioner: FSM encodings and counter sizing.
// Pure compile-time content; no logic, no latency.
// No flow control; nothing here carries data.
package btn_cond_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    // Bits needed for a counter that runs 0 .. n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous level inputs.
// Latency: two clk edges from input change to q.
// No backpressure; free-running sampler.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back samples; only the second stage is safe to use.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_pulse_conditioner.sv
// Raw button -> synchronise -> debounce -> edge detect -> optional auto-repeat pulses.
// Latency: first pulse DEBOUNCE_CYCLES+2 edges after a clean press.
// No backpressure; pulse_out is a one-cycle enable, never high two cycles in a row.
module btn_pulse_conditioner
    import btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_CYCLES     = 5000000,
    parameter int REPEAT_CYCLES   = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic level_out,
    output logic pulse_out,
    output logic repeating
);

    localparam int DB_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam int TMR_W = cnt_width(max_int(HOLD_CYCLES, REPEAT_CYCLES));

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);

    logic             btn_sync;
    logic [DB_W-1:0]  db_cnt;
    logic [TMR_W-1:0] tmr;
    state_t           state;
    logic             db_accept;
    logic             press;
    logic             release_btn;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_raw),
        .q     (btn_sync)
    );

    // A new level is accepted on the edge where the disagreeing run completes;
    // the FSM reacts on that same edge so the pulse lines up with level_out.
    assign db_accept   = (btn_sync != level_out) && (db_cnt == DB_LAST);
    assign press       = db_accept &&  btn_sync;
    assign release_btn = db_accept && !btn_sync;

    // Debounce: count consecutive disagreeing samples, any agreeing sample restarts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_out <= 1'b0;
            db_cnt    <= '0;
        end else if (btn_sync == level_out) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            level_out <= btn_sync;
            db_cnt    <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Press/hold/repeat FSM with registered pulse; release overrides everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tmr       <= '0;
            pulse_out <= 1'b0;
            repeating <= 1'b0;
        end else begin
            pulse_out <= 1'b0;
            if (release_btn) begin
                state     <= ST_IDLE;
                tmr       <= '0;
                repeating <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (press) begin
                            pulse_out <= 1'b1;
                            tmr       <= '0;
                            state     <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (!repeat_en) begin
                            tmr <= '0;
                        end else if (tmr == HOLD_LAST) begin
                            pulse_out <= 1'b1;
                            tmr       <= '0;
                            state     <= ST_REPEAT;
                            repeating <= 1'b1;
                        end else begin
                            tmr <= tmr + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (!repeat_en) begin
                            tmr       <= '0;
                            state     <= ST_HOLD;
                            repeating <= 1'b0;
                        end else if (tmr == REP_LAST) begin
                            pulse_out <= 1'b1;
                            tmr       <= '0;
                        end else begin
                            tmr <= tmr + 1'b1;
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        tmr       <= '0;
                        repeating <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_btn_pulse_conditioner.sv
module tb_btn_pulse_conditioner;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_raw;
    logic repeat_en;
    logic level_out;
    logic pulse_out;
    logic repeating;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Per-window history: bit e holds the output observed just after edge e.
    int          en;
    logic [63:0] pv, lv, rv;
    logic [63:0] exp_p, exp_l, exp_r;

    always #5 clk = ~clk;

    btn_pulse_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (10),
        .REPEAT_CYCLES   (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .repeat_en (repeat_en),
        .level_out (level_out),
        .pulse_out (pulse_out),
        .repeating (repeating)
    );

    task automatic open_window();
        en    = 0;
        pv    = '0;
        lv    = '0;
        rv    = '0;
        exp_p = '0;
        exp_l = '0;
        exp_r = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        en++;
        if (en < 64) begin
            pv[en] = pulse_out;
            lv[en] = level_out;
            rv[en] = repeating;
        end
    endtask

    task automatic settle();
        btn_raw   = 1'b0;
        repeat_en = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        btn_raw   = 1'b1;
        repeat_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if ({level_out, pulse_out, repeating} !== 3'b000)
                $display("FAIL reset_outputs cycle %0d got %b want 000", i, {level_out, pulse_out, repeating});
            else
                pass_cnt++;
        end
        rst_n = 1'b1;
        open_window();
        for (int e = 1; e <= 10; e++) tick();
        exp_p[6] = 1'b1;
        for (int e = 6; e <= 10; e++) exp_l[e] = 1'b1;
        total_cnt++;
        if (pv !== exp_p) $display("FAIL reset_first_pulse got %h want %h", pv, exp_p);
        else pass_cnt++;
        total_cnt++;
        if (lv !== exp_l) $display("FAIL reset_level got %h want %h", lv, exp_l);
        else pass_cnt++;
        total_cnt++;
        if (rv !== exp_r) $display("FAIL reset_repeating got %h want %h", rv, exp_r);
        else pass_cnt++;
        settle();
    endtask

    task automatic test_clean_press();
        repeat_en = 1'b0;
        open_window();
        for (int e = 1; e <= 25; e++) begin
            btn_raw = (e <= 12);
            tick();
        end
        exp_p[6] = 1'b1;
        for (int e = 6; e <= 17; e++) exp_l[e] = 1'b1;
        total_cnt++;
        if (pv !== exp_p) $display("FAIL press_pulse got %h want %h", pv, exp_p);
        else pass_cnt++;
        total_cnt++;
        if (lv !== exp_l) $display("FAIL press_level got %h want %h", lv, exp_l);
        else pass_cnt++;
        total_cnt++;
        if (rv !== exp_r) $display("FAIL press_repeating got %h want %h", rv, exp_r);
        else pass_cnt++;
        settle();
    endtask

    task automatic test_bounce();
        repeat_en = 1'b0;
        open_window();
        for (int e = 1; e <= 35; e++) begin
            btn_raw = (e <= 20) ? (((e - 1) / 2) % 2 == 0) : 1'b1;
            tick();
        end
        exp_p[26] = 1'b1;
        for (int e = 26; e <= 35; e++) exp_l[e] = 1'b1;
        total_cnt++;
        if (pv !== exp_p) $display("FAIL bounce_pulse got %h want %h", pv, exp_p);
        else pass_cnt++;
        total_cnt++;
        if (lv !== exp_l) $display("FAIL bounce_level got %h want %h", lv, exp_l);
        else pass_cnt++;
        settle();
    endtask

    task automatic test_glitch();
        repeat_en = 1'b0;
        open_window();
        for (int e = 1; e <= 15; e++) begin
            btn_raw = (e <= 3);
            tick();
        end
        total_cnt++;
        if (pv !== exp_p) $display("FAIL glitch_pulse got %h want %h", pv, exp_p);
        else pass_cnt++;
        total_cnt++;
        if (lv !== exp_l) $display("FAIL glitch_level got %h want %h", lv, exp_l);
        else pass_cnt++;
        settle();
    endtask

    task automatic test_auto_repeat();
        repeat_en = 1'b1;
        open_window();
        for (int e = 1; e <= 45; e++) begin
            btn_raw = (e <= 30);
            tick();
        end
        exp_p[6]  = 1'b1;
        exp_p[16] = 1'b1;
        for (int e = 19; e <= 34; e += 3) exp_p[e] = 1'b1;
        for (int e = 6; e <= 35; e++)  exp_l[e] = 1'b1;
        for (int e = 16; e <= 35; e++) exp_r[e] = 1'b1;
        total_cnt++;
        if (pv !== exp_p) $display("FAIL repeat_pulse got %h want %h", pv, exp_p);
        else pass_cnt++;
        total_cnt++;
        if (lv !== exp_l) $display("FAIL repeat_level got %h want %h", lv, exp_l);
        else pass_cnt++;
        total_cnt++;
        if (rv !== exp_r) $display("FAIL repeat_flag got %h want %h", rv, exp_r);
        else pass_cnt++;
        total_cnt++;
        if ((pv & (pv >> 1)) !== 64'd0) $display("FAIL repeat_back_to_back got %h want 0", pv & (pv >> 1));
        else pass_cnt++;
        settle();
    endtask

    task automatic test_reset_in_repeat();
        repeat_en = 1'b1;
        btn_raw   = 1'b1;
        open_window();
        for (int e = 1; e <= 18; e++) tick();
        total_cnt++;
        if (repeating !== 1'b1) $display("FAIL midreset_in_repeat got %b want 1", repeating);
        else pass_cnt++;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({level_out, pulse_out, repeating} !== 3'b000)
            $display("FAIL midreset_outputs got %b want 000", {level_out, pulse_out, repeating});
        else
            pass_cnt++;
        rst_n = 1'b1;
        open_window();
        for (int e = 1; e <= 12; e++) tick();
        exp_p[6] = 1'b1;
        for (int e = 6; e <= 12; e++) exp_l[e] = 1'b1;
        total_cnt++;
        if (pv !== exp_p) $display("FAIL midreset_pulse got %h want %h", pv, exp_p);
        else pass_cnt++;
        total_cnt++;
        if (lv !== exp_l) $display("FAIL midreset_level got %h want %h", lv, exp_l);
        else pass_cnt++;
        total_cnt++;
        if (rv !== exp_r) $display("FAIL midreset_repeating got %h want %h", rv, exp_r);
        else pass_cnt++;
        settle();
    endtask

    initial begin
        rst_n     = 1'b0;
        btn_raw   = 1'b0;
        repeat_en = 1'b0;
        #1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_auto_repeat();
        test_reset_in_repeat();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
